spmv_csr_sequencer: RTL and testbench
=====================================

// Module: spmv_csr_sequencer
// PURPOSE
//  Sequences one sparse matrix-vector multiply (CSR format) through SpMV_core.
//  Loads the row-pointer array from a shared 1-cycle-latency read memory, then streams each
//  nonzero to the core as an FP16 (A value, x[col]) pair with an element index.
//  Holds the core start, waits for core done, and reports completion or error to the host.
// PARAMETERS
//  N_ROWS    16   matrix rows; row_ptr has N_ROWS+1 entries of 8 bits each
//  ADDR_W    10   memory word-address width
//  PTR_BASE  0    word address of row_ptr[0]
//  COL_BASE  32   word address of col_idx[0]
//  VAL_BASE  288  word address of val[0] (FP16)
//  X_BASE    544  word address of x[0] (FP16)
// PORTS
//  i_clk         in   1                 clock, rising edge
//  i_rstn        in   1                 asynchronous active-low reset
//  i_start       in   1                 start request; sampled only in IDLE
//  o_busy        out  1                 high in every state except IDLE
//  o_done        out  1                 one-cycle pulse at end of job
//  o_err         out  1                 error flag; valid with o_done, held until next start
//  o_mem_en      out  1                 memory read enable
//  o_mem_addr    out  ADDR_W            memory word address
//  i_mem_rdata   in   16                read data, valid the cycle after o_mem_en
//  o_core_start  out  1                 start level to SpMV_core
//  o_data_A      out  16                FP16 matrix value to core
//  o_data_B      out  16                FP16 x[col] to core
//  o_count       out  8                 elements issued so far; core index
//  o_row_ptr     out  8*(N_ROWS+1)      packed row_ptr; entry k at [8k+7:8k]
//  i_core_done   in   1                 core finished accumulating
// BEHAVIOUR
//  Reset: all outputs 0, FSM in IDLE, internal counters 0; reset mid-job aborts with no o_done.
//  States: IDLE, LOAD_PTR, CHECK, F_COL, F_VAL, F_X, ISSUE, WAIT_CORE, DONE.
//  IDLE: on i_start go to LOAD_PTR; clear o_err, o_count, o_row_ptr.
//  LOAD_PTR: N_ROWS+1 back-to-back reads at PTR_BASE+k. Store rdata[7:0] into entry k one
//   cycle later. Takes N_ROWS+2 cycles total.
//  CHECK (1 cycle): nnz = row_ptr[N_ROWS]. Error if row_ptr[0]!=0 or any entry < predecessor.
//   On error: set o_err, go to DONE, leave core untouched.
//   If nnz==0: raise o_core_start and go to WAIT_CORE.
//   Else: raise o_core_start and go to F_COL with element index e=0.
//  o_core_start stays high from CHECK exit until DONE; it drops in DONE.
//  Each element takes 4 cycles, non-overlapped:
//   F_COL:  read COL_BASE+e.
//   F_VAL:  read VAL_BASE+e; latch col = rdata[7:0].
//   F_X:    read X_BASE+col; latch val = rdata.
//   ISSUE:  o_data_A<=val, o_data_B<=rdata, o_count<=e+1; then e++.
//           If e+1==nnz go to WAIT_CORE, else go to F_COL.
//  o_data_A/B and o_count change only in ISSUE and hold their value between issues.
//  o_mem_en is high only in LOAD_PTR read cycles, F_COL, F_VAL and F_X; o_mem_addr is 0 otherwise.
//  Address arithmetic is modulo 2^ADDR_W; wrap is not flagged.
//  col >= N_ROWS is not checked; the x address simply wraps.
//  WAIT_CORE: stay until i_core_done=1, then go to DONE.
//   i_core_done seen in any other state is ignored.
//  DONE: o_done=1 for one cycle, o_core_start=0, return to IDLE.
//   o_row_ptr, o_count, o_data_* and o_err hold until the next start.
//  i_start while busy is ignored, including in the DONE cycle.
//  Latency from start to the first ISSUE is N_ROWS+2+1+4 cycles (23 at default).
// TESTING
//  T1 CSR walk: row_ptr=00,00,01,02,02,03,04,04,04,07,07,07,07,09,09,09,0a; all val=0x4C00 (16.0),
//   x=0x4000 (2.0), col_idx=0..9 -> o_row_ptr=136'h0a_09_09_09_07_07_07_07_04_04_04_03_02_02_01_00_00;
//   o_count steps 1..10, one step every 4 cycles; first step 23 cycles after start;
//   A=0x4C00, B=0x4000 at each step.
//  T2 gather: col_idx[3]=15, x[15]=0x3C00 -> 4th issue has B=0x3C00;
//   o_mem_addr in F_X = 559.
//  T3 zero nnz: all row_ptr=0 -> no F_COL reads; o_core_start high;
//   assert i_core_done 5 cycles later -> o_done 1 cycle later, o_err=0.
//  T4 bad ptr: row_ptr[5]=3, row_ptr[6]=2 -> o_err=1 with o_done;
//   o_core_start never rises; o_count=0.
//  T5 reset mid-job: drop i_rstn during element 4 -> all outputs 0 at once, FSM in IDLE;
//   new start reruns T1 identically.
//  T6 start while busy: pulse i_start during WAIT_CORE and during DONE -> ignored;
//   exactly one o_done per accepted start.

Source files
------------

// File: rtl/spmv_csr_sequencer.sv
// spmv_csr_sequencer: walks one CSR sparse matrix from memory and
// streams (A value, x[col]) pairs with an element index to SpMV_core.
module spmv_csr_sequencer #(
  parameter int N_ROWS   = 16,
  parameter int ADDR_W   = 10,
  parameter int PTR_BASE = 0,
  parameter int COL_BASE = 32,
  parameter int VAL_BASE = 288,
  parameter int X_BASE   = 544
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic                  i_start,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err,
  output logic                  o_mem_en,
  output logic [ADDR_W-1:0]     o_mem_addr,
  input  logic [15:0]           i_mem_rdata,
  output logic                  o_core_start,
  output logic [15:0]           o_data_A,
  output logic [15:0]           o_data_B,
  output logic [7:0]            o_count,
  output logic [8*(N_ROWS+1)-1:0] o_row_ptr,
  input  logic                  i_core_done
);

  localparam int PW = 8 * (N_ROWS + 1);
  localparam int KW = $clog2(N_ROWS + 2);

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_CHECK, S_FCOL, S_FVAL,
    S_FX, S_ISSUE, S_WAIT, S_DONE
  } state_t;

  state_t        r_state;
  logic [KW-1:0] r_k;
  logic [7:0]    r_e;
  logic [15:0]   r_val;

  logic          w_err;
  logic [7:0]    w_nnz;
  logic [7:0]    w_e1;

  function automatic logic [ADDR_W-1:0] addr_of(
    input int base,
    input int off
  );
    return ADDR_W'(base + off);
  endfunction

  assign w_nnz = o_row_ptr[PW-1 -: 8];
  assign w_e1  = r_e + 8'd1;

  always_comb begin
    w_err = (o_row_ptr[7:0] != 8'd0);
    for (int k = 1; k <= N_ROWS; k++)
      if (o_row_ptr[8*k +: 8] < o_row_ptr[8*(k-1) +: 8])
        w_err = 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state      <= S_IDLE;
      r_k          <= '0;
      r_e          <= '0;
      r_val        <= '0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
      o_err        <= 1'b0;
      o_mem_en     <= 1'b0;
      o_mem_addr   <= '0;
      o_core_start <= 1'b0;
      o_data_A     <= '0;
      o_data_B     <= '0;
      o_count      <= '0;
      o_row_ptr    <= '0;
    end else begin
      o_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_state    <= S_LOAD;
            r_k        <= '0;
            o_busy     <= 1'b1;
            o_err      <= 1'b0;
            o_count    <= '0;
            o_row_ptr  <= '0;
            o_mem_en   <= 1'b1;
            o_mem_addr <= addr_of(PTR_BASE, 0);
          end
        end
        S_LOAD: begin
          // entries arrive in order; shifting from the top lands k at slot k
          if (r_k != '0)
            o_row_ptr <= {i_mem_rdata[7:0], o_row_ptr[PW-1:8]};
          r_k <= r_k + KW'(1);
          if (r_k < KW'(N_ROWS)) begin
            o_mem_en   <= 1'b1;
            o_mem_addr <= addr_of(PTR_BASE, int'(r_k) + 1);
          end else begin
            o_mem_en   <= 1'b0;
            o_mem_addr <= '0;
          end
          if (r_k == KW'(N_ROWS + 1))
            r_state <= S_CHECK;
        end
        S_CHECK: begin
          r_e <= '0;
          if (w_err) begin
            o_err   <= 1'b1;
            o_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            o_core_start <= 1'b1;
            if (w_nnz == 8'd0) begin
              r_state <= S_WAIT;
            end else begin
              r_state    <= S_FCOL;
              o_mem_en   <= 1'b1;
              o_mem_addr <= addr_of(COL_BASE, 0);
            end
          end
        end
        S_FCOL: begin
          r_state    <= S_FVAL;
          o_mem_addr <= addr_of(VAL_BASE, int'(r_e));
        end
        S_FVAL: begin
          r_state    <= S_FX;
          o_mem_addr <= addr_of(X_BASE, int'(i_mem_rdata[7:0]));
        end
        S_FX: begin
          r_state    <= S_ISSUE;
          r_val      <= i_mem_rdata;
          o_mem_en   <= 1'b0;
          o_mem_addr <= '0;
        end
        S_ISSUE: begin
          o_data_A <= r_val;
          o_data_B <= i_mem_rdata;
          o_count  <= w_e1;
          r_e      <= w_e1;
          if (w_e1 == w_nnz) begin
            r_state <= S_WAIT;
          end else begin
            r_state    <= S_FCOL;
            o_mem_en   <= 1'b1;
            o_mem_addr <= addr_of(COL_BASE, int'(w_e1));
          end
        end
        S_WAIT: begin
          if (i_core_done) begin
            r_state      <= S_DONE;
            o_done       <= 1'b1;
            o_core_start <= 1'b0;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          o_busy  <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spmv_csr_sequencer.sv
// tb_spmv_csr_sequencer: directed table-driven bench with a
// 1-cycle-latency memory model for spmv_csr_sequencer.
module tb_spmv_csr_sequencer;

  localparam logic [135:0] EXP_PTR =
    136'h0a_09_09_09_07_07_07_07_04_04_04_03_02_02_01_00_00;

  typedef struct {
    logic [7:0]  cnt;
    logic [15:0] a;
    logic [15:0] b;
    logic [9:0]  fx;
  } vec_t;

  logic         clk = 1'b0;
  logic         i_rstn, i_start, i_core_done;
  logic         o_busy, o_done, o_err, o_mem_en, o_core_start;
  logic [9:0]   o_mem_addr;
  logic [15:0]  i_mem_rdata;
  logic [15:0]  o_data_A, o_data_B;
  logic [7:0]   o_count;
  logic [135:0] o_row_ptr;

  logic [15:0] mem [0:1023];
  logic [7:0]  t1p [0:16] = '{
    8'h00, 8'h00, 8'h01, 8'h02, 8'h02, 8'h03, 8'h04, 8'h04, 8'h04,
    8'h07, 8'h07, 8'h07, 8'h07, 8'h09, 8'h09, 8'h09, 8'h0a};

  vec_t vecs [0:19];
  int   n_vec = 0;
  int   n_bad = 0;
  int   n_done = 0;
  int   t = 0;
  int   d0;

  spmv_csr_sequencer dut (
    .i_clk        (clk),
    .i_rstn       (i_rstn),
    .i_start      (i_start),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_err        (o_err),
    .o_mem_en     (o_mem_en),
    .o_mem_addr   (o_mem_addr),
    .i_mem_rdata  (i_mem_rdata),
    .o_core_start (o_core_start),
    .o_data_A     (o_data_A),
    .o_data_B     (o_data_B),
    .o_count      (o_count),
    .o_row_ptr    (o_row_ptr),
    .i_core_done  (i_core_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (o_mem_en) i_mem_rdata <= mem[o_mem_addr];

  always @(posedge clk)
    if (o_done) n_done <= n_done + 1;

  task automatic tick();
    @(posedge clk);
    #1;
    t++;
  endtask

  task automatic chk(input string nm, input logic [135:0] act,
                     input logic [135:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0d)", nm, act, exp, t);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, o_busy, 0);
    chk({tag, "_done"}, o_done, 0);
    chk({tag, "_err"}, o_err, 0);
    chk({tag, "_mem_en"}, o_mem_en, 0);
    chk({tag, "_mem_addr"}, o_mem_addr, 0);
    chk({tag, "_core_start"}, o_core_start, 0);
    chk({tag, "_A"}, o_data_A, 0);
    chk({tag, "_B"}, o_data_B, 0);
    chk({tag, "_count"}, o_count, 0);
    chk({tag, "_row_ptr"}, o_row_ptr, 0);
  endtask

  task automatic load_t1();
    for (int i = 0; i < 1024; i++) mem[i] = 16'h0;
    for (int i = 0; i < 17; i++) mem[i] = {8'h00, t1p[i]};
    for (int i = 0; i < 10; i++) begin
      mem[32 + i]  = 16'(i);
      mem[288 + i] = 16'h4C00;
    end
    for (int i = 0; i < 16; i++) mem[544 + i] = 16'h4000;
  endtask

  task automatic load_zero();
    for (int i = 0; i < 1024; i++) mem[i] = 16'h0;
  endtask

  task automatic go();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    t = 0;
  endtask

  task automatic run_walk(input int base);
    go();
    chk("walk_busy", o_busy, 1);
    chk("walk_err_clr", o_err, 0);
    chk("walk_count_clr", o_count, 0);
    while (t < 18) tick();
    chk("walk_cs_pre", o_core_start, 0);
    tick();
    chk("walk_cs", o_core_start, 1);
    chk("walk_row_ptr", o_row_ptr, EXP_PTR);
    for (int e = 0; e < 10; e++) begin
      while (t < 21 + 4 * e) tick();
      chk("walk_fx_addr", {o_mem_en, o_mem_addr},
          {1'b1, vecs[base + e].fx});
      tick();
      chk("walk_count_hold", o_count, 8'(e));
      tick();
      chk("walk_count", o_count, vecs[base + e].cnt);
      chk("walk_A", o_data_A, vecs[base + e].a);
      chk("walk_B", o_data_B, vecs[base + e].b);
    end
    tick();
    tick();
    chk("walk_wait_nodone", o_done, 0);
    chk("walk_wait_cs", o_core_start, 1);
    i_core_done = 1'b1;
    tick();
    i_core_done = 1'b0;
    chk("walk_done", o_done, 1);
    chk("walk_done_cs", o_core_start, 0);
    chk("walk_done_err", o_err, 0);
    tick();
    chk("walk_done_pulse", o_done, 0);
    chk("walk_idle_busy", o_busy, 0);
    chk("walk_count_held", o_count, 10);
    chk("walk_ptr_held", o_row_ptr, EXP_PTR);
  endtask

  initial begin
    for (int e = 0; e < 10; e++) begin
      vecs[e]      = '{8'(e + 1), 16'h4C00, 16'h4000, 10'(544 + e)};
      vecs[10 + e] = '{8'(e + 1), 16'h4C00,
                       (e == 3) ? 16'h3C00 : 16'h4000,
                       (e == 3) ? 10'd559 : 10'(544 + e)};
    end

    i_rstn = 1'b0;
    i_start = 1'b0;
    i_core_done = 1'b0;
    load_t1();
    repeat (3) tick();
    chk_zero("reset");
    i_rstn = 1'b1;
    tick();

    // T1 and T2
    run_walk(0);
    load_t1();
    mem[35]  = 16'd15;
    mem[559] = 16'h3C00;
    run_walk(10);

    // T3: empty matrix, early core_done ignored
    load_zero();
    go();
    repeat (5) tick();
    i_core_done = 1'b1;
    tick();
    tick();
    i_core_done = 1'b0;
    while (t < 18) tick();
    chk("t3_busy", o_busy, 1);
    chk("t3_nodone", o_done, 0);
    tick();
    chk("t3_cs", o_core_start, 1);
    chk("t3_no_read", o_mem_en, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t3_no_read", o_mem_en, 0);
    end
    i_core_done = 1'b1;
    tick();
    i_core_done = 1'b0;
    chk("t3_done", o_done, 1);
    chk("t3_err", o_err, 0);
    chk("t3_cs_drop", o_core_start, 0);
    tick();
    chk("t3_done_pulse", o_done, 0);
    chk("t3_idle", o_busy, 0);

    // T4: decreasing row_ptr
    load_t1();
    mem[5] = 16'h0003;
    mem[6] = 16'h0002;
    go();
    while (t < 19) begin
      chk("t4_cs_low", o_core_start, 0);
      tick();
    end
    chk("t4_done", o_done, 1);
    chk("t4_err", o_err, 1);
    chk("t4_cs", o_core_start, 0);
    chk("t4_count", o_count, 0);
    tick();
    chk("t4_done_pulse", o_done, 0);
    chk("t4_idle", o_busy, 0);
    chk("t4_err_held", o_err, 1);

    // T5: reset during element 4, then rerun
    load_t1();
    go();
    while (t < 36) tick();
    chk("t5_count_pre", o_count, 4);
    i_rstn = 1'b0;
    #1;
    chk_zero("t5_reset");
    #2;
    i_rstn = 1'b1;
    run_walk(0);

    // T6: start while busy
    load_zero();
    d0 = n_done;
    go();
    while (t < 19) tick();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    chk("t6_no_restart", o_mem_en, 0);
    chk("t6_busy", o_busy, 1);
    i_core_done = 1'b1;
    tick();
    i_core_done = 1'b0;
    i_start = 1'b1;
    chk("t6_done", o_done, 1);
    tick();
    i_start = 1'b0;
    chk("t6_idle", o_busy, 0);
    tick();
    chk("t6_no_load", o_mem_en, 0);
    chk("t6_still_idle", o_busy, 0);
    repeat (3) tick();
    chk("t6_one_done", 136'(n_done - d0), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
